// File: rtl/bin_arith_pkg.sv
// Shared constants for the binary adder / subtractor family.
// Holds the default operand width and the serial FSM state encoding.
package bin_arith_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bin_sub_serial.sv
// Bit-serial subtractor recovering num2 = sum - num1, LSB first, one bit per clock.
// Used to check the binary adder: diff must equal the original num2 with fits=1.
module bin_sub_serial
  import bin_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] num1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff,
  output logic             borrow,
  output logic             fits
);

  localparam int CW = $clog2(WIDTH + 2);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] a_sr_q, a_sr_d;
  logic [WIDTH:0] b_sr_q, b_sr_d;
  logic [WIDTH:0] r_sr_q, r_sr_d;
  logic           bor_q, bor_d;
  logic [WIDTH:0] diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           fits_q, fits_d;

  logic           d_bit;
  logic           bout_bit;
  logic [WIDTH:0] r_shifted;

  full_sub u_full_sub (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bor_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign r_shifted = {d_bit, r_sr_q[WIDTH:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    fits_d   = fits_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = sum;
          b_sr_d  = {1'b0, num1};
          r_sr_d  = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = r_shifted;
        bor_d  = bout_bit;
        cnt_d  = cnt_q + 1'b1;
        // Results are latched on the final bit so they are valid alongside done.
        if (cnt_q == CW'(WIDTH)) begin
          diff_d   = r_shifted;
          borrow_d = bout_bit;
          fits_d   = ~bout_bit & ~d_bit;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      bor_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      fits_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      fits_q   <= fits_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign fits   = fits_q;

endmodule

// File: tb/tb_bin_sub_serial.sv
// Directed self-checking bench for bin_sub_serial (WIDTH=4).
module tb_bin_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] sum_i;
  logic [3:0] num1_i;
  logic       busy;
  logic       done;
  logic [4:0] diff;
  logic       borrow;
  logic       fits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_sub_serial #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sum    (sum_i),
    .num1   (num1_i),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .fits   (fits)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE, wait (bounded) for done, return to IDLE.
  task automatic do_op(input logic [4:0] s, input logic [3:0] n, output int lat);
    sum_i  = s;
    num1_i = n;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    check_eq("done_pulse_width", 32'(done), 32'd0);
  endtask

  task automatic op_check(input string tag, input logic [4:0] s, input logic [3:0] n,
                          input logic [4:0] exp_d, input logic exp_b, input logic exp_f);
    int lat;
    do_op(s, n, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd6);
    check_eq({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check_eq({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
    check_eq({tag, "_fits"}, 32'(fits), 32'(exp_f));
    $display("op %s: sum=%0d num1=%0d -> diff=%0d borrow=%0d fits=%0d lat=%0d",
             tag, s, n, diff, borrow, fits, lat);
    finish_op();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int lat;
    logic [4:0] done_diff;
    logic [4:0] s;

    rst    = 1'b1;
    start  = 1'b0;
    sum_i  = '0;
    num1_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. quiet after reset
    for (int i = 0; i < 10; i++) begin
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_diff", 32'(diff), 32'd0);
      check_eq("rst_borrow", 32'(borrow), 32'd0);
      check_eq("rst_fits", 32'(fits), 32'd0);
      @(posedge clk); #1;
    end
    $display("reset: outputs quiet for 10 cycles");

    // 2. normal subtractions
    op_check("s8_n3", 5'd8, 4'd3, 5'd5, 1'b0, 1'b1);
    op_check("s9_n4", 5'd9, 4'd4, 5'd5, 1'b0, 1'b1);
    op_check("s18_n9", 5'd18, 4'd9, 5'd9, 1'b0, 1'b1);

    // 3. borrow and out-of-range boundaries
    op_check("s3_n9", 5'd3, 4'd9, 5'd26, 1'b1, 1'b0);
    op_check("s31_n0", 5'd31, 4'd0, 5'd31, 1'b0, 1'b0);
    op_check("s0_n0", 5'd0, 4'd0, 5'd0, 1'b0, 1'b1);
    op_check("s0_n15", 5'd0, 4'd15, 5'd17, 1'b1, 1'b0);

    // 4. start during SHIFT is ignored
    sum_i  = 5'd8;
    num1_i = 4'd3;
    start  = 1'b1;
    @(posedge clk); #1;
    sum_i     = 5'd0;
    num1_i    = 4'd1;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_diff = '0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_diff = diff;
      end
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("ign_busy_cycles", 32'(busy_cnt), 32'd5);
    check_eq("ign_done_count", 32'(done_cnt), 32'd1);
    check_eq("ign_diff", 32'(done_diff), 32'd5);
    $display("op ignore_start: busy=%0d cycles done=%0d diff=%0d", busy_cnt, done_cnt, done_diff);

    // 5. reset mid-operation aborts
    sum_i  = 5'd20;
    num1_i = 4'd7;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    check_eq("abort_done_count", 32'(done_cnt), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_diff", 32'(diff), 32'd0);
    check_eq("abort_borrow", 32'(borrow), 32'd0);
    check_eq("abort_fits", 32'(fits), 32'd0);
    $display("op abort: done=%0d busy=%0d diff=%0d", done_cnt, busy, diff);
    op_check("post_abort", 5'd0, 4'd0, 5'd0, 1'b0, 1'b1);

    // 6. adder round trip
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        s = 5'(a + b);
        do_op(s, 4'(a), lat);
        check_eq("rt_latency", 32'(lat), 32'd6);
        check_eq("rt_diff", 32'(diff), 32'(b));
        check_eq("rt_fits", 32'(fits), 32'd1);
        check_eq("rt_borrow", 32'(borrow), 32'd0);
        $display("roundtrip num1=%0d num2=%0d sum=%0d -> diff=%0d", a, b, s, diff);
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
